// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic              RegDst,
    input  logic              Branch,
    input  logic              MemToReg,
    input  logic              Mem_Write,
    input  logic              Mem_Read,
    input  logic [1:0]        ALUop,
    input  logic [1:0]        ALUsrc,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              ex_RegWrite,
    output logic              ex_RegDst,
    output logic              ex_Branch,
    output logic              ex_MemToReg,
    output logic              ex_Mem_Write,
    output logic              ex_Mem_Read,
    output logic [1:0]        ex_ALUop,
    output logic [1:0]        ex_ALUsrc,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_valid,
    output logic              stall,
    output logic [31:0]       stall_count
);

    logic              r_RegWrite, r_RegDst, r_Branch, r_MemToReg;
    logic              r_Mem_Write, r_Mem_Read, r_valid;
    logic [1:0]        r_ALUop, r_ALUsrc;
    logic [DATA_W-1:0] r_pc, r_rs_data, r_rt_data, r_imm;
    logic [REG_AW-1:0] r_rs, r_rt, r_rd;

    logic w_stall;
    logic w_bubble;

    // Load in EX whose destination is read by the instruction in ID; r0 never hazards.
    assign w_stall = r_valid & r_Mem_Read & (r_rt != '0) & id_valid &
                     ((r_rt == id_rs) | (r_rt == id_rt)) & ~flush;

    assign w_bubble = flush | w_stall | ~id_valid;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_RegWrite  <= 1'b0;
            r_RegDst    <= 1'b0;
            r_Branch    <= 1'b0;
            r_MemToReg  <= 1'b0;
            r_Mem_Write <= 1'b0;
            r_Mem_Read  <= 1'b0;
            r_ALUop     <= 2'b00;
            r_ALUsrc    <= 2'b00;
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
        end else begin
            r_RegWrite  <= RegWrite;
            r_RegDst    <= RegDst;
            r_Branch    <= Branch;
            r_MemToReg  <= MemToReg;
            r_Mem_Write <= Mem_Write;
            r_Mem_Read  <= Mem_Read;
            r_ALUop     <= ALUop;
            r_ALUsrc    <= ALUsrc;
            r_valid     <= 1'b1;
            r_pc        <= id_pc;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rd        <= id_rd;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 32'd0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 32'd0;
`endif

    assign ex_RegWrite  = r_RegWrite;
    assign ex_RegDst    = r_RegDst;
    assign ex_Branch    = r_Branch;
    assign ex_MemToReg  = r_MemToReg;
    assign ex_Mem_Write = r_Mem_Write;
    assign ex_Mem_Read  = r_Mem_Read;
    assign ex_ALUop     = r_ALUop;
    assign ex_ALUsrc    = r_ALUsrc;
    assign ex_pc        = r_pc;
    assign ex_rs_data   = r_rs_data;
    assign ex_rt_data   = r_rt_data;
    assign ex_imm       = r_imm;
    assign ex_rs        = r_rs;
    assign ex_rt        = r_rt;
    assign ex_rd        = r_rd;
    assign ex_valid     = r_valid;
    assign stall        = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX bundle queued at drive time, compared after the edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        RegWrite;
        logic        RegDst;
        logic        Branch;
        logic        MemToReg;
        logic        Mem_Write;
        logic        Mem_Read;
        logic [1:0]  ALUop;
        logic [1:0]  ALUsrc;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst, RegWrite, RegDst, Branch, MemToReg, Mem_Write, Mem_Read;
    logic [1:0]  ALUop, ALUsrc;
    logic        id_valid, flush;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_RegWrite, ex_RegDst, ex_Branch, ex_MemToReg, ex_Mem_Write, ex_Mem_Read;
    logic [1:0]  ex_ALUop, ex_ALUsrc;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_valid, stall;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    ex_t         exp_q[$];
    ex_t         m_ex;
    logic [31:0] m_cnt;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .RegDst(RegDst), .Branch(Branch), .MemToReg(MemToReg),
        .Mem_Write(Mem_Write), .Mem_Read(Mem_Read), .ALUop(ALUop), .ALUsrc(ALUsrc),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst), .ex_Branch(ex_Branch),
        .ex_MemToReg(ex_MemToReg), .ex_Mem_Write(ex_Mem_Write), .ex_Mem_Read(ex_Mem_Read),
        .ex_ALUop(ex_ALUop), .ex_ALUsrc(ex_ALUsrc), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ex_t observed();
        ex_t o;
        o = '{ex_valid, ex_RegWrite, ex_RegDst, ex_Branch, ex_MemToReg, ex_Mem_Write,
              ex_Mem_Read, ex_ALUop, ex_ALUsrc, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
              ex_rs, ex_rt, ex_rd};
        return o;
    endfunction

    function automatic ex_t from_inputs();
        ex_t e;
        e = '{1'b1, RegWrite, RegDst, Branch, MemToReg, Mem_Write, Mem_Read, ALUop, ALUsrc,
              id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd};
        return e;
    endfunction

    // Inputs already driven (after a negedge); check combinational stall, queue the
    // expected EX contents, then compare after the rising edge.
    task automatic cycle(input string tag);
        ex_t  e;
        logic es;
        #1;
        es = m_ex.valid & m_ex.Mem_Read & (m_ex.rt != 5'd0) & id_valid &
             ((m_ex.rt == id_rs) | (m_ex.rt == id_rt)) & ~flush;
        check({tag, "_stall"}, 160'(stall), 160'(es));
        check({tag, "_cnt"}, 160'(stall_count), 160'(m_cnt));
        if (rst || flush || es || !id_valid) e = '0;
        else                                 e = from_inputs();
        exp_q.push_back(e);
`ifdef STALL_CNT_EN
        if (rst)                                     m_cnt = 32'd0;
        else if (es && m_cnt != 32'hFFFF_FFFF)       m_cnt = m_cnt + 32'd1;
`endif
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 160'(0), 160'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_ex"}, 160'(observed()), 160'(e));
            m_ex = e;
        end
    endtask

    task automatic set_rand();
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; id_valid = 1'b1;
        RegWrite = 1'($urandom); RegDst = 1'($urandom); Branch = 1'($urandom);
        MemToReg = 1'($urandom); Mem_Write = 1'($urandom); Mem_Read = 1'b0;
        ALUop = 2'($urandom); ALUsrc = 2'($urandom);
        id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    endtask

    task automatic set_lw(input logic [4:0] rt);
        set_rand();
        Mem_Read = 1'b1; Mem_Write = 1'b0; RegWrite = 1'b1; MemToReg = 1'b1;
        id_rt = rt; id_rs = 5'd20;
    endtask

    task automatic set_dep(input logic [4:0] rs, input logic [4:0] rt);
        set_rand();
        RegWrite = 1'b1; Mem_Write = 1'b1; id_rs = rs; id_rt = rt;
    endtask

    initial begin
        m_ex = '0; m_cnt = 32'd0;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b1;
        RegWrite = 1'b1; RegDst = 1'b1; Branch = 1'b1; MemToReg = 1'b1;
        Mem_Write = 1'b1; Mem_Read = 1'b1; ALUop = 2'b11; ALUsrc = 2'b11;
        id_pc = 32'hDEAD_BEEF; id_rs_data = 32'h1; id_rt_data = 32'h2; id_imm = 32'h3;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        @(negedge clk);
        // Reset with every input active: first edge must leave EX all zero.
        @(posedge clk); #1;
        check("reset_ex", 160'(observed()), 160'(0));
        check("reset_cnt", 160'(stall_count), 160'(0));
        m_ex = '0;
        @(negedge clk);
        cycle("reset2");

        // R-type pass-through
        set_rand();
        RegWrite = 1'b1; RegDst = 1'b1; Branch = 1'b0; MemToReg = 1'b0;
        Mem_Write = 1'b0; ALUop = 2'b10; ALUsrc = 2'b00; id_rd = 5'd3; id_pc = 32'h40;
        cycle("rtype");
        check("rtype_regwrite", 160'(ex_RegWrite), 160'(1));
        check("rtype_aluop", 160'(ex_ALUop), 160'(2'b10));
        check("rtype_rd", 160'(ex_rd), 160'(3));
        check("rtype_pc", 160'(ex_pc), 160'(32'h40));
        check("rtype_valid", 160'(ex_valid), 160'(1));
        check("rtype_nostall", 160'(stall), 160'(0));

        // Load-use: one-cycle stall, bubble, then the dependent instruction proceeds
        set_lw(5'd8);
        cycle("lw8");
        set_dep(5'd8, 5'd1);
        #1;
        check("lu_stall_hi", 160'(stall), 160'(1));
        cycle("lu_dep");
        check("lu_bubble_valid", 160'(ex_valid), 160'(0));
        check("lu_bubble_ctrl", 160'({ex_RegWrite, ex_RegDst, ex_Branch, ex_MemToReg,
                                      ex_Mem_Write, ex_Mem_Read, ex_ALUop, ex_ALUsrc}), 160'(0));
        check("lu_stall_lo", 160'(stall), 160'(0));
        cycle("lu_dep_retry");
        check("lu_dep_valid", 160'(ex_valid), 160'(1));

        // r0 never hazards
        set_lw(5'd0);
        cycle("lw0");
        set_dep(5'd0, 5'd0);
        cycle("r0_dep");
        check("r0_nostall_valid", 160'(ex_valid), 160'(1));

        // Store in EX never stalls
        set_rand(); Mem_Write = 1'b1; id_rt = 5'd8;
        cycle("sw8");
        set_dep(5'd3, 5'd8);
        cycle("sw_dep");
        check("sw_nostall_valid", 160'(ex_valid), 160'(1));

        // Flush beats stall
        set_lw(5'd8);
        cycle("lw8b");
        set_dep(5'd8, 5'd8);
        flush = 1'b1;
        cycle("flush_dep");
        check("flush_bubble", 160'({ex_valid, ex_Mem_Write, ex_RegWrite}), 160'(0));

        // id_valid low gives a bubble whatever the control bits
        set_dep(5'd4, 5'd5);
        id_valid = 1'b0;
        cycle("idinvalid");

        // Reset while a load-use hazard is pending
        set_lw(5'd9);
        cycle("lw9");
        set_dep(5'd9, 5'd9);
        rst = 1'b1;
        cycle("rst_mid");
        check("rst_mid_nostall", 160'(stall), 160'(0));
        check("rst_mid_cnt", 160'(stall_count), 160'(0));

`ifdef STALL_CNT_EN
        @(negedge clk);
        dut.r_stall_count = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            set_lw(5'd8);
            cycle("sat_lw");
            set_dep(5'd8, 5'd0);
            cycle("sat_dep");
        end
        check("sat_count", 160'(stall_count), 160'(32'hFFFF_FFFF));
`endif

        // Constrained-random mix with a small register space to provoke hazards
        for (int i = 0; i < 300; i++) begin
            set_rand();
            Mem_Read = 1'($urandom_range(0, 1));
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_valid = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 29) == 0);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DATA_W, default 32, width of datapath words (PC, operands, immediate).
REQ-002 Parameter: REG_AW, default 5, width of register specifiers.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 RegWrite, RegDst, Branch, MemToReg, Mem_Write, Mem_Read  input  1 each  decode-stage control bits from the control unit.
REQ-006 ALUop, ALUsrc  input  2 each  decode-stage ALU control fields.
REQ-007 id_valid  input  1  decode stage holds a real instruction.
REQ-008 id_pc, id_rs_data, id_rt_data, id_imm  input  DATA_W each  decode-stage PC, operands, sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  input  REG_AW each  decode-stage register specifiers.
REQ-010 flush  input  1  squash request from a later stage (taken branch).
REQ-011 ex_* (ex_RegWrite ... ex_ALUsrc, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd)  output  same widths as inputs  registered execute-stage copies.
REQ-012 ex_valid  output  1  execute stage holds a real instruction.
REQ-013 stall  output  1  load-use hazard; drives control unit stall and freezes PC and IF/ID.
REQ-014 stall_count  output  32  stall-cycle counter (see Configuration).

Function
REQ-015 Every field SHALL register on each rising clk edge; latency decode to execute is exactly 1 cycle.
REQ-016 stall SHALL be combinational: ex_valid & ex_Mem_Read & (ex_rt != 0) & id_valid & (ex_rt == id_rs | ex_rt == id_rt) & !flush.
REQ-017 When stall=1, the next edge SHALL load a bubble: all eight control outputs 0, ex_valid 0; data/specifier outputs don't-care but SHALL load 0.
REQ-018 The block SHALL insert the bubble itself, independent of the control bits presented by the control unit.
REQ-019 A load-use stall SHALL last exactly 1 cycle: after the bubble, ex_valid=0 forces stall=0.
REQ-020 flush=1 SHALL load a bubble on the next edge and SHALL force stall=0 in the same cycle; flush has priority over stall.
REQ-021 id_valid=0 SHALL load a bubble regardless of input control bits.
REQ-022 Register r0 SHALL never cause a hazard (ex_rt == 0 excluded).
REQ-023 A store (Mem_Read=0) in execute SHALL never cause stall.
REQ-024 Bubble encoding SHALL prevent any register write or memory access downstream.

Reset
REQ-025 rst=1 at an edge SHALL clear all ex_* outputs and ex_valid to 0; stall therefore reads 0 in the following cycle.
REQ-026 rst SHALL override flush, stall and all inputs; reset mid-stall SHALL abandon the stall with no residual state.
REQ-027 stall_count SHALL reset to 0.

Configuration
REQ-028 Macro STALL_CNT_EN: when defined, stall_count SHALL increment by 1 on each edge where stall=1 and rst=0, saturating at 32'hFFFF_FFFF.
REQ-029 Without STALL_CNT_EN, stall_count SHALL be constant 0 and no counter register SHALL be synthesized; all other behaviour is identical.

Verification
REQ-030 R-type pass-through: id_valid=1, RegWrite=1, RegDst=1, ALUop=2'b10, id_rd=5'd3, id_pc=32'h40 -> next cycle ex_RegWrite=1, ex_ALUop=2'b10, ex_rd=3, ex_pc=32'h40, ex_valid=1, stall=0.
REQ-031 Load-use: LW into ex_rt=5'd8 followed by id_rs=5'd8 -> stall=1 for exactly 1 cycle, next cycle ex_valid=0 and all controls 0, then stall=0; stall_count=1 with STALL_CNT_EN.
REQ-032 r0 and store exclusion: LW with ex_rt=0 and id_rs=0 -> stall=0; SW (Mem_Read=0) with ex_rt=5'd8, id_rt=5'd8 -> stall=0.
REQ-033 Flush vs stall: load-use condition present and flush=1 same cycle -> stall=0, next cycle bubble (ex_valid=0, ex_Mem_Write=0, ex_RegWrite=0).
REQ-034 Reset mid-operation: pipeline valid with LW in execute, assert rst for one edge -> all ex_* =0, ex_valid=0, stall=0, stall_count=0.
REQ-035 Counter saturation (STALL_CNT_EN): preload count 32'hFFFF_FFFE, force 3 stall cycles -> count holds 32'hFFFF_FFFF.
